// File: rtl/ps2_pkg.sv
// Shared scan-code constants, controller state encoding and byte classifier
// for the PS/2 keyboard controller.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_ACK   = 8'hFA;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_ECHO  = 8'hEE;
  localparam logic [7:0] SC_ERR0  = 8'h00;
  localparam logic [7:0] SC_ERR1  = 8'hFF;
  localparam logic [7:0] SC_ERR2  = 8'hFC;
  localparam logic [7:0] SC_ERR3  = 8'hFD;

  // Bytes of the Pause sequence that follow the leading E1.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StPop,
    StDecode
  } ctrl_state_e;

  typedef enum logic [2:0] {
    ByteExt,
    ByteBrk,
    BytePause,
    ByteIgnore,
    ByteErr,
    ByteKey
  } byte_class_e;

  function automatic byte_class_e classify(input logic [7:0] b);
    byte_class_e c;
    case (b)
      SC_EXT:                            c = ByteExt;
      SC_BRK:                            c = ByteBrk;
      SC_PAUSE:                          c = BytePause;
      SC_ACK, SC_BAT, SC_ECHO:           c = ByteIgnore;
      SC_ERR0, SC_ERR1, SC_ERR2, SC_ERR3: c = ByteErr;
      default:                           c = ByteKey;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ps2_key_bitmap.sv
// 512-entry held-key bitmap: one synchronous set/clear port and a
// combinational read port, both indexed by {ext, scan code}.
module ps2_key_bitmap (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       we_i,
  input  logic       wbit_i,
  input  logic [8:0] widx_i,
  input  logic [8:0] ridx_i,
  output logic       rbit_o
);

  logic [511:0] bits_q, bits_d;

  always_comb begin
    bits_d = bits_q;
    if (we_i) bits_d[widx_i] = wbit_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) bits_q <= '0;
    else       bits_q <= bits_d;
  end

  assign rbit_o = bits_q[ridx_i];

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Drains the PS/2 receiver FIFO and turns Set-2 scan-code sequences into
// single key events, tracking held keys, presses and protocol errors.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter bit FILTER_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kbd_data,
  input  logic       kbd_ready,
  input  logic       kbd_ovf,
  output logic       kbd_nextdata_n,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [8:0] held_cnt,
  output logic [7:0] press_cnt,
  output logic [7:0] err_cnt,
  output logic       ovf_seen
);

  ctrl_state_e state_q, state_d;

  logic [7:0] byte_q, byte_d;
  logic       ext_pend_q, ext_pend_d;
  logic       brk_pend_q, brk_pend_d;
  logic [2:0] skip_cnt_q, skip_cnt_d;
  logic       ev_valid_q, ev_valid_d;
  logic [7:0] ev_code_q, ev_code_d;
  logic       ev_ext_q, ev_ext_d;
  logic       ev_break_q, ev_break_d;
  logic [8:0] held_cnt_q, held_cnt_d;
  logic [7:0] press_cnt_q, press_cnt_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       ovf_seen_q, ovf_seen_d;

  logic       bm_we, bm_wbit, key_held;
  logic [8:0] key_idx;

  assign key_idx = {ext_pend_q, byte_q};

  ps2_key_bitmap u_bitmap (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (bm_we),
    .wbit_i (bm_wbit),
    .widx_i (key_idx),
    .ridx_i (key_idx),
    .rbit_o (key_held)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; a pending event blocks any further pop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (kbd_ready && !ev_valid_q) state_d = StPop;
      StPop:    state_d = StDecode;
      StDecode: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    kbd_nextdata_n = 1'b1;
    if (state_q == StPop) kbd_nextdata_n = 1'b0;
  end

  // Datapath: byte capture, decode and event slot
  always_comb begin
    byte_d      = byte_q;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    skip_cnt_d  = skip_cnt_q;
    ev_valid_d  = ev_valid_q;
    ev_code_d   = ev_code_q;
    ev_ext_d    = ev_ext_q;
    ev_break_d  = ev_break_q;
    held_cnt_d  = held_cnt_q;
    press_cnt_d = press_cnt_q;
    err_cnt_d   = err_cnt_q;
    ovf_seen_d  = ovf_seen_q | kbd_ovf;
    bm_we       = 1'b0;
    bm_wbit     = 1'b0;

    if (ev_valid_q && ev_ready) ev_valid_d = 1'b0;

    // Head byte is captured on the edge that enters StPop.
    if (state_q == StIdle && kbd_ready && !ev_valid_q) byte_d = kbd_data;

    // The slot is always empty in StDecode, so emitting never overwrites.
    if (state_q == StDecode) begin
      if (skip_cnt_q != 3'd0) begin
        skip_cnt_d = skip_cnt_q - 3'd1;
      end else begin
        case (classify(byte_q))
          ByteExt: ext_pend_d = 1'b1;
          ByteBrk: brk_pend_d = 1'b1;
          BytePause: begin
            ev_valid_d = 1'b1;
            ev_code_d  = SC_PAUSE;
            ev_ext_d   = 1'b0;
            ev_break_d = 1'b0;
            skip_cnt_d = PAUSE_SKIP;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end
          ByteErr: begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end
          ByteKey: begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
            if (brk_pend_q) begin
              ev_valid_d = 1'b1;
              ev_code_d  = byte_q;
              ev_ext_d   = ext_pend_q;
              ev_break_d = 1'b1;
              if (key_held) begin
                bm_we      = 1'b1;
                bm_wbit    = 1'b0;
                held_cnt_d = held_cnt_q - 9'd1;
              end
            end else if (!key_held || !FILTER_REPEAT) begin
              ev_valid_d  = 1'b1;
              ev_code_d   = byte_q;
              ev_ext_d    = ext_pend_q;
              ev_break_d  = 1'b0;
              press_cnt_d = press_cnt_q + 8'd1;
              if (!key_held) begin
                bm_we      = 1'b1;
                bm_wbit    = 1'b1;
                held_cnt_d = held_cnt_q + 9'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q      <= 8'h00;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      skip_cnt_q  <= 3'd0;
      ev_valid_q  <= 1'b0;
      ev_code_q   <= 8'h00;
      ev_ext_q    <= 1'b0;
      ev_break_q  <= 1'b0;
      held_cnt_q  <= 9'd0;
      press_cnt_q <= 8'd0;
      err_cnt_q   <= 8'd0;
      ovf_seen_q  <= 1'b0;
    end else begin
      byte_q      <= byte_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      skip_cnt_q  <= skip_cnt_d;
      ev_valid_q  <= ev_valid_d;
      ev_code_q   <= ev_code_d;
      ev_ext_q    <= ev_ext_d;
      ev_break_q  <= ev_break_d;
      held_cnt_q  <= held_cnt_d;
      press_cnt_q <= press_cnt_d;
      err_cnt_q   <= err_cnt_d;
      ovf_seen_q  <= ovf_seen_d;
    end
  end

  assign ev_valid  = ev_valid_q;
  assign ev_code   = ev_code_q;
  assign ev_ext    = ev_ext_q;
  assign ev_break  = ev_break_q;
  assign held_cnt  = held_cnt_q;
  assign press_cnt = press_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign ovf_seen  = ovf_seen_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench: receiver FIFO models feed two controllers (repeat filter on
// and off); expected events are queued with the stimulus and checked on transfer.
module tb_ps2_kbd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       kbd_ovf;
  logic       ev_ready;
  logic       kbd_nextdata_n, ev_valid, ev_ext, ev_break, ovf_seen;
  logic [7:0] kbd_data, ev_code, press_cnt, err_cnt;
  logic [8:0] held_cnt;
  logic       kbd_ready;

  logic       nf_ovf = 1'b0;
  logic       nf_ev_ready = 1'b1;
  logic       nf_nextdata_n, nf_ev_valid, nf_ev_ext, nf_ev_break, nf_ovf_seen;
  logic [7:0] nf_data, nf_ev_code, nf_press_cnt, nf_err_cnt;
  logic [8:0] nf_held_cnt;
  logic       nf_ready;

  // FIFOs are append-only; the monitors advance read pointers on each pop.
  logic [7:0]  fifo[$];
  logic [7:0]  fifo_nf[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_nf[$];
  int rd_ptr = 0, rd_nf = 0, exp_ptr = 0, exp_ptr_nf = 0, pops = 0;
  logic prev_n = 1'b1, prev_nf = 1'b1;

  int n_checks = 0;
  int n_errs   = 0;

  assign kbd_ready = rd_ptr < fifo.size();
  assign kbd_data  = (rd_ptr < fifo.size()) ? fifo[rd_ptr] : 8'h00;
  assign nf_ready  = rd_nf < fifo_nf.size();
  assign nf_data   = (rd_nf < fifo_nf.size()) ? fifo_nf[rd_nf] : 8'h00;

  ps2_kbd_ctrl #(.FILTER_REPEAT(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_ovf        (kbd_ovf),
    .kbd_nextdata_n (kbd_nextdata_n),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_code        (ev_code),
    .ev_ext         (ev_ext),
    .ev_break       (ev_break),
    .held_cnt       (held_cnt),
    .press_cnt      (press_cnt),
    .err_cnt        (err_cnt),
    .ovf_seen       (ovf_seen)
  );

  ps2_kbd_ctrl #(.FILTER_REPEAT(1'b0)) dut_nf (
    .clk            (clk),
    .rst            (rst),
    .kbd_data       (nf_data),
    .kbd_ready      (nf_ready),
    .kbd_ovf        (nf_ovf),
    .kbd_nextdata_n (nf_nextdata_n),
    .ev_valid       (nf_ev_valid),
    .ev_ready       (nf_ev_ready),
    .ev_code        (nf_ev_code),
    .ev_ext         (nf_ev_ext),
    .ev_break       (nf_ev_break),
    .held_cnt       (nf_held_cnt),
    .press_cnt      (nf_press_cnt),
    .err_cnt        (nf_err_cnt),
    .ovf_seen       (nf_ovf_seen)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Main receiver model and event scoreboard
  always @(negedge clk) begin
    prev_n <= kbd_nextdata_n;
    if (!kbd_nextdata_n) begin
      check("pop_pulse_width", {31'd0, prev_n}, 32'd1);
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
    if (ev_valid && ev_ready) begin
      if (exp_ptr >= exp_q.size()) check("unexpected_event", exp_ptr, exp_q.size());
      else check("event", {22'd0, ev_code, ev_ext, ev_break}, exp_q[exp_ptr]);
      exp_ptr <= exp_ptr + 1;
    end
  end

  always @(negedge clk) begin
    prev_nf <= nf_nextdata_n;
    if (!nf_nextdata_n) begin
      check("nf_pop_pulse_width", {31'd0, prev_nf}, 32'd1);
      rd_nf <= rd_nf + 1;
    end
    if (nf_ev_valid && nf_ev_ready) begin
      if (exp_ptr_nf >= exp_nf.size()) check("nf_unexpected_event", exp_ptr_nf, exp_nf.size());
      else check("nf_event", {22'd0, nf_ev_code, nf_ev_ext, nf_ev_break}, exp_nf[exp_ptr_nf]);
      exp_ptr_nf <= exp_ptr_nf + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic exp_ev(input logic [7:0] c, input logic e, input logic b);
    exp_q.push_back({22'd0, c, e, b});
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (!(rd_ptr == fifo.size() && exp_ptr == exp_q.size() &&
             rd_nf == fifo_nf.size() && exp_ptr_nf == exp_nf.size()) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_timeout", {31'd0, cyc < 3000}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic drive_at_posedge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] snap;
    int         pops0;
    bit         found;
    logic [7:0] rep_seq [5];
    rep_seq = '{8'h1B, 8'h1B, 8'h1B, 8'hF0, 8'h1B};

    rst = 1'b1; ev_ready = 1'b0; kbd_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_nextdata_n", {31'd0, kbd_nextdata_n}, 32'd1);
    check("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
    check("rst_ev_fields", {22'd0, ev_code, ev_ext, ev_break}, 32'd0);
    check("rst_held", held_cnt, 32'd0);
    check("rst_press", press_cnt, 32'd0);
    check("rst_err", err_cnt, 32'd0);
    check("rst_ovf_seen", {31'd0, ovf_seen}, 32'd0);
    drive_at_posedge();
    rst = 1'b0; ev_ready = 1'b1;

    // Press and release 'A'
    push(8'h1C); exp_ev(8'h1C, 1'b0, 1'b0);
    wait_drain();
    check("a_held_after_make", held_cnt, 32'd1);
    push(8'hF0); push(8'h1C); exp_ev(8'h1C, 1'b0, 1'b1);
    wait_drain();
    check("a_held_after_break", held_cnt, 32'd0);
    check("a_press", press_cnt, 32'd1);
    check("a_pops", pops, 32'd3);

    // Typematic repeat, filtered and unfiltered
    for (int i = 0; i < 5; i++) begin
      push(rep_seq[i]);
      fifo_nf.push_back(rep_seq[i]);
    end
    exp_ev(8'h1B, 1'b0, 1'b0); exp_ev(8'h1B, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) exp_nf.push_back({22'd0, 8'h1B, 1'b0, 1'b0});
    exp_nf.push_back({22'd0, 8'h1B, 1'b0, 1'b1});
    wait_drain();
    check("rep_press", press_cnt, 32'd2);
    check("rep_held", held_cnt, 32'd0);
    check("nf_press", nf_press_cnt, 32'd3);
    check("nf_held", nf_held_cnt, 32'd0);

    // Extended Up arrow
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    exp_ev(8'h75, 1'b1, 1'b0); exp_ev(8'h75, 1'b1, 1'b1);
    wait_drain();
    check("ext_held", held_cnt, 32'd0);
    check("ext_press", press_cnt, 32'd3);

    // Pause: one event, tail bytes leave the bitmap alone
    push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
    push(8'hF0); push(8'h14); push(8'hF0); push(8'h77);
    exp_ev(8'hE1, 1'b0, 1'b0);
    wait_drain();
    check("pause_held", held_cnt, 32'd0);
    push(8'h14); exp_ev(8'h14, 1'b0, 1'b0);
    wait_drain();
    check("post_pause_make_held", held_cnt, 32'd1);
    push(8'hF0); push(8'h14); exp_ev(8'h14, 1'b0, 1'b1);
    // Prefixes in F0,E0 order
    push(8'hE0); push(8'h75); exp_ev(8'h75, 1'b1, 1'b0);
    push(8'hF0); push(8'hE0); push(8'h75); exp_ev(8'h75, 1'b1, 1'b1);
    // ACK between prefix and code is discarded, prefix kept
    push(8'hE0); push(8'hFA); push(8'h6B); exp_ev(8'h6B, 1'b1, 1'b0);
    push(8'hE0); push(8'hF0); push(8'h6B); exp_ev(8'h6B, 1'b1, 1'b1);
    wait_drain();
    check("prefix_press", press_cnt, 32'd6);
    check("prefix_held", held_cnt, 32'd0);

    // Errors: count, clear prefixes, saturate
    push(8'h00);
    wait_drain();
    check("err_first", err_cnt, 32'd1);
    push(8'hF0); push(8'h00); push(8'h2A); exp_ev(8'h2A, 1'b0, 1'b0);
    wait_drain();
    check("err_clears_brk", held_cnt, 32'd1);
    check("err_second", err_cnt, 32'd2);
    push(8'hF0); push(8'h2A); exp_ev(8'h2A, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) push(8'hFF);
    wait_drain();
    check("err_saturate", err_cnt, 32'd255);
    check("err_press", press_cnt, 32'd7);

    // Back-pressure
    drive_at_posedge();
    ev_ready = 1'b0;
    pops0 = pops;
    push(8'h1C); push(8'h32); push(8'h21);
    exp_ev(8'h1C, 1'b0, 1'b0); exp_ev(8'h32, 1'b0, 1'b0); exp_ev(8'h21, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    check("bp_one_pop", pops - pops0, 32'd1);
    check("bp_valid", {31'd0, ev_valid}, 32'd1);
    check("bp_fields", {22'd0, ev_code, ev_ext, ev_break}, {22'd0, 8'h1C, 2'b00});
    snap = {ev_code, ev_ext, ev_break};
    repeat (10) @(negedge clk);
    check("bp_stable", {22'd0, ev_code, ev_ext, ev_break}, {22'd0, snap});
    check("bp_still_one_pop", pops - pops0, 32'd1);
    drive_at_posedge();
    ev_ready = 1'b1;
    wait_drain();
    check("bp_press", press_cnt, 32'd10);
    check("bp_held", held_cnt, 32'd3);
    push(8'hF0); push(8'h1C); push(8'hF0); push(8'h32); push(8'hF0); push(8'h21);
    exp_ev(8'h1C, 1'b0, 1'b1); exp_ev(8'h32, 1'b0, 1'b1); exp_ev(8'h21, 1'b0, 1'b1);
    wait_drain();
    check("bp_held_released", held_cnt, 32'd0);

    // Overflow is sticky
    drive_at_posedge();
    kbd_ovf = 1'b1;
    drive_at_posedge();
    kbd_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("ovf_set", {31'd0, ovf_seen}, 32'd1);
    repeat (20) @(negedge clk);
    check("ovf_sticky", {31'd0, ovf_seen}, 32'd1);

    // Reset during POP drops the popped byte
    push(8'h1C);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (!kbd_nextdata_n) found = 1'b1;
    end
    check("midpop_seen", {31'd0, found}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midpop_nextdata_n", {31'd0, kbd_nextdata_n}, 32'd1);
    check("midpop_ev_valid", {31'd0, ev_valid}, 32'd0);
    check("midpop_fields", {22'd0, ev_code, ev_ext, ev_break}, 32'd0);
    check("midpop_counts", {7'd0, held_cnt, press_cnt, err_cnt}, 32'd0);
    check("midpop_ovf_cleared", {31'd0, ovf_seen}, 32'd0);
    drive_at_posedge();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midpop_no_event", {31'd0, ev_valid}, 32'd0);
    push(8'h1C); exp_ev(8'h1C, 1'b0, 1'b0);
    wait_drain();
    check("post_rst_press", press_cnt, 32'd1);
    check("post_rst_held", held_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
